usb_rx_resp_ctrl: RTL and testbench
===================================

USB_RX_RESP_CTRL -- requirements
Module: usb_rx_resp_ctrl

Interface
REQ-001 Parameter TURN_CYC, default 16: cycles from end of received DATA packet to response start.
REQ-002 Parameter DATA_TOUT, default 255: max cycles waiting for DATA after OUT token.
REQ-003 Parameter MAX_OCC, default 64: buffer capacity in bytes.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 rx_packet  in  4  RX PID code: 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, others ignored.
REQ-007 rx_data_ready  in  1  one-cycle pulse: rx_packet valid, packet complete.
REQ-008 rx_error  in  1  level: current/last RX packet bad (PID/EOP/stuff error).
REQ-009 rx_trans_active  in  1  level: RX packet in progress on bus.
REQ-010 buffer_occupancy  in  7  current RX buffer bytes, 0..MAX_OCC.
REQ-011 tx_done  in  1  one-cycle pulse: TX handshake packet fully sent.
REQ-012 tx_packet  out  4  handshake code to send: 5 ACK, 6 NAK, 0 none.
REQ-013 tx_start  out  1  one-cycle pulse requesting TX of tx_packet.
REQ-014 flush_req  out  1  one-cycle pulse: discard bytes of last DATA packet.
REQ-015 data_toggle  out  1  expected DATA PID: 0 DATA0, 1 DATA1.
REQ-016 resp_busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_DATA, TURNAROUND, SEND, WAIT_TX.
REQ-018 IDLE: rx_data_ready with rx_packet=1 and rx_error=0 -> WAIT_DATA, timeout counter cleared; all other PIDs ignored, stay IDLE.
REQ-019 WAIT_DATA: counter increments each cycle rx_trans_active=0; counter reaching DATA_TOUT -> IDLE, no response, no flush.
REQ-020 WAIT_DATA, rx_data_ready with rx_error=1 -> IDLE, flush_req pulse, no response.
REQ-021 WAIT_DATA, rx_data_ready with rx_packet not 3/4 (and rx_error=0) -> IDLE, no response.
REQ-022 Valid DATA, buffer_occupancy > MAX_OCC -> response NAK, flush_req pulse, toggle unchanged.
REQ-023 Valid DATA, PID matches data_toggle, occupancy <= MAX_OCC -> response ACK, data_toggle inverts on same edge as TURNAROUND entry.
REQ-024 Valid DATA, PID mismatches data_toggle (duplicate) -> response ACK, flush_req pulse, toggle unchanged.
REQ-025 Overflow check (REQ-022) SHALL take priority over toggle check.
REQ-026 Response decision SHALL be registered; TURNAROUND entered the cycle after rx_data_ready.
REQ-027 TURNAROUND: counter counts TURN_CYC cycles; restarts from 0 any cycle rx_trans_active=1; on reaching TURN_CYC -> SEND.
REQ-028 SEND: tx_start=1 and tx_packet=response for exactly one cycle, then WAIT_TX.
REQ-029 tx_packet SHALL hold response from SEND through WAIT_TX, 0 otherwise.
REQ-030 WAIT_TX: tx_done -> IDLE; tx_done in any other state ignored.
REQ-031 rx_data_ready during TURNAROUND/SEND/WAIT_TX SHALL be ignored (no state or toggle change).
REQ-032 flush_req SHALL be asserted exactly one cycle, the cycle after the triggering rx_data_ready.
REQ-033 Counters SHALL be 8-bit, saturating, never wrap.

Reset
REQ-034 n_rst low SHALL asynchronously force IDLE, counters 0, data_toggle 0, tx_packet 0, tx_start 0, flush_req 0, resp_busy 0.
REQ-035 Reset mid-transaction SHALL abandon it; no tx_start or flush_req after release until new OUT token.
REQ-036 First rx_data_ready SHALL be honoured on the first rising edge after n_rst deasserts.

Verification
REQ-037 OUT, then DATA0 with occupancy 10 -> TURNAROUND 16 cycles, tx_start with tx_packet=5, data_toggle 0->1, tx_done -> IDLE.
REQ-038 toggle=1, OUT then DATA0 -> tx_packet=5, flush_req one pulse, data_toggle stays 1.
REQ-039 OUT then DATA1 with occupancy 65 -> tx_packet=6, flush_req one pulse, toggle unchanged.
REQ-040 OUT, then no packet for 255 idle cycles -> IDLE, resp_busy 0, no tx_start; next DATA0 ignored.
REQ-041 OUT, DATA0 with rx_error=1 -> flush_req pulse, no tx_start; rx_trans_active pulse during TURNAROUND of a later valid transfer delays tx_start by 16 cycles from its fall.
REQ-042 n_rst asserted in TURNAROUND with toggle=1 -> all outputs 0, data_toggle 0 immediately, no tx_start after release.

Source files
------------

// File: rtl/usb_rx_resp_ctrl.sv
// Handshake responder for a USB OUT transaction: waits for the DATA packet after an
// OUT token, decides ACK/NAK, waits the bus turnaround time, then launches the handshake.
//
// state      | meaning
// IDLE       | waiting for a clean OUT token
// WAIT_DATA  | OUT seen, waiting for DATA0/DATA1 (timeout on idle bus cycles)
// TURNAROUND | response decided, waiting for the bus turnaround gap
// SEND       | tx_start pulse with the chosen handshake
// WAIT_TX    | handshake in flight, waiting for tx_done
module usb_rx_resp_ctrl #(
    parameter int TURN_CYC  = 16,
    parameter int DATA_TOUT = 255,
    parameter int MAX_OCC   = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_error,
    input  logic       rx_trans_active,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_done,
    output logic [3:0] tx_packet,
    output logic       tx_start,
    output logic       flush_req,
    output logic       data_toggle,
    output logic       resp_busy
);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, TURNAROUND, SEND, WAIT_TX} state_t;

    localparam logic [3:0] PID_OUT   = 4'd1;
    localparam logic [3:0] PID_DATA0 = 4'd3;
    localparam logic [3:0] PID_DATA1 = 4'd4;
    localparam logic [3:0] PID_ACK   = 4'd5;
    localparam logic [3:0] PID_NAK   = 4'd6;

    // Terminal-count values: the transition happens on the edge the counter would reach the limit.
    localparam logic [7:0] TOUT_LAST = 8'(DATA_TOUT - 1);
    localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);
    localparam logic [6:0] OCC_MAX   = 7'(MAX_OCC);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] resp;
    logic [7:0] cnt_inc;
    logic       is_data;
    logic       pid_toggle;

    assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign is_data    = (rx_packet == PID_DATA0) || (rx_packet == PID_DATA1);
    assign pid_toggle = (rx_packet == PID_DATA1);
    assign resp_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            resp        <= 4'd0;
            tx_packet   <= 4'd0;
            tx_start    <= 1'b0;
            flush_req   <= 1'b0;
            data_toggle <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            flush_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_data_ready && rx_packet == PID_OUT && !rx_error) begin
                        state <= WAIT_DATA;
                        cnt   <= 8'd0;
                    end
                end
                WAIT_DATA: begin
                    if (rx_data_ready) begin
                        if (rx_error) begin
                            flush_req <= 1'b1;
                            state     <= IDLE;
                        end else if (is_data) begin
                            cnt   <= 8'd0;
                            state <= TURNAROUND;
                            // Overflow outranks the toggle check; a duplicate is ACKed but dropped.
                            if (buffer_occupancy > OCC_MAX) begin
                                resp      <= PID_NAK;
                                flush_req <= 1'b1;
                            end else if (pid_toggle == data_toggle) begin
                                resp        <= PID_ACK;
                                data_toggle <= ~data_toggle;
                            end else begin
                                resp      <= PID_ACK;
                                flush_req <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!rx_trans_active) begin
                        if (cnt >= TOUT_LAST)
                            state <= IDLE;
                        else
                            cnt <= cnt_inc;
                    end
                end
                TURNAROUND: begin
                    if (rx_trans_active) begin
                        cnt <= 8'd0;
                    end else if (cnt >= TURN_LAST) begin
                        state     <= SEND;
                        tx_start  <= 1'b1;
                        tx_packet <= resp;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        state     <= IDLE;
                        tx_packet <= 4'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_resp_ctrl.sv
// Bench for usb_rx_resp_ctrl: directed vector table, hand sequences for timeout/reset,
// and random OUT/DATA transactions checked against a transaction-level model.
module tb_usb_rx_resp_ctrl;
    localparam int TURN_CYC  = 16;
    localparam int DATA_TOUT = 255;
    localparam int MAX_OCC   = 64;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] rx_packet = 4'd0;
    logic       rx_data_ready = 1'b0;
    logic       rx_error = 1'b0;
    logic       rx_trans_active = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_done = 1'b0;
    logic [3:0] tx_packet;
    logic       tx_start;
    logic       flush_req;
    logic       data_toggle;
    logic       resp_busy;

    int n_chk = 0;
    int n_fail = 0;
    logic model_toggle = 1'b0;

    usb_rx_resp_ctrl #(.TURN_CYC(TURN_CYC), .DATA_TOUT(DATA_TOUT), .MAX_OCC(MAX_OCC)) dut (
        .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_error(rx_error), .rx_trans_active(rx_trans_active),
        .buffer_occupancy(buffer_occupancy), .tx_done(tx_done), .tx_packet(tx_packet),
        .tx_start(tx_start), .flush_req(flush_req), .data_toggle(data_toggle),
        .resp_busy(resp_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [3:0] pid, input logic err, input logic [6:0] occ);
        rx_packet = pid;
        rx_error = err;
        buffer_occupancy = occ;
        rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        rx_error = 1'b0;
    endtask

    // One OUT + DATA transaction; expectations come from the handshake rules, not the DUT.
    task automatic do_txn(input string tag, input logic [3:0] pid, input logic err,
                          input logic [6:0] occ, input int active_at, input logic noise);
        bit   exp_start, exp_flush;
        int   exp_pkt, exp_delay;
        logic exp_tog;
        int   flushes, flush_k, ks, pkt, starts;
        exp_start = 0; exp_flush = 0; exp_pkt = 0; exp_tog = model_toggle;
        if (err) begin
            exp_flush = 1;
        end else if (pid == 4'd3 || pid == 4'd4) begin
            exp_start = 1;
            if (int'(occ) > MAX_OCC) begin
                exp_pkt = 6; exp_flush = 1;
            end else if ((pid == 4'd4) == model_toggle) begin
                exp_pkt = 5; exp_tog = ~model_toggle;
            end else begin
                exp_pkt = 5; exp_flush = 1;
            end
        end
        exp_delay = (active_at < 0) ? TURN_CYC : active_at + 1 + TURN_CYC;

        send_pkt(4'd1, 1'b0, 7'd0);
        step();
        step();
        send_pkt(pid, err, occ);
        flushes = 0; flush_k = -1; ks = -1; pkt = 0; starts = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 0) begin
                chk({tag, "_toggle"}, int'(data_toggle), int'(exp_tog));
                chk({tag, "_txpkt_pre"}, int'(tx_packet), 0);
            end
            if (flush_req) begin
                flushes++;
                if (flush_k < 0) flush_k = k;
            end
            if (tx_start) begin
                starts++;
                if (ks < 0) begin ks = k; pkt = int'(tx_packet); end
            end
            if (ks >= 0 && k == ks + 1)
                chk({tag, "_txpkt_hold"}, int'(tx_packet), exp_pkt);
            rx_trans_active = (k == active_at);
            rx_packet = 4'd4;
            rx_data_ready = noise && (k == 8);
            tx_done = (noise && k == 9) || (ks >= 0 && k == ks + 2);
            step();
        end
        rx_trans_active = 1'b0; rx_data_ready = 1'b0; tx_done = 1'b0;
        chk({tag, "_flush_cnt"}, flushes, int'(exp_flush));
        if (exp_flush) chk({tag, "_flush_cycle"}, flush_k, 0);
        chk({tag, "_start_cnt"}, starts, int'(exp_start));
        if (exp_start) begin
            chk({tag, "_start_delay"}, ks, exp_delay);
            chk({tag, "_txpkt"}, pkt, exp_pkt);
        end
        chk({tag, "_busy_end"}, int'(resp_busy), 0);
        chk({tag, "_txpkt_end"}, int'(tx_packet), 0);
        model_toggle = exp_tog;
    endtask

    typedef struct {
        logic [3:0] pid;
        logic       err;
        logic [6:0] occ;
        int         active_at;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   cnt_start, cnt_flush;
        vecs[0] = '{4'd3, 1'b0, 7'd10, -1};   // DATA0 match: ACK, toggle 0->1
        vecs[1] = '{4'd3, 1'b0, 7'd10, -1};   // duplicate DATA0: ACK + flush
        vecs[2] = '{4'd4, 1'b0, 7'd65, -1};   // overflow: NAK + flush
        vecs[3] = '{4'd4, 1'b0, 7'd64, -1};   // occupancy at limit: ACK, toggle 1->0
        vecs[4] = '{4'd3, 1'b0, 7'd0,  -1};   // wait: error case below replaces it
        vecs[4] = '{4'd3, 1'b1, 7'd0,  -1};   // rx_error: flush only
        vecs[5] = '{4'd3, 1'b0, 7'd20,  3};   // bus activity delays tx_start
        vecs[6] = '{4'd5, 1'b0, 7'd0,  -1};   // non-DATA PID: dropped
        vecs[7] = '{4'd3, 1'b0, 7'd65, -1};   // overflow beats toggle mismatch
        vecs[8] = '{4'd4, 1'b0, 7'd0,  -1};   // DATA1 match

        #12;
        chk("rst_tx_packet", int'(tx_packet), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_flush", int'(flush_req), 0);
        chk("rst_toggle", int'(data_toggle), 0);
        chk("rst_busy", int'(resp_busy), 0);

        @(posedge clk);
        #1;
        n_rst = 1'b1;
        send_pkt(4'd1, 1'b0, 7'd0);
        chk("first_edge_out", int'(resp_busy), 1);
        send_pkt(4'd6, 1'b0, 7'd0);
        chk("non_data_idle", int'(resp_busy), 0);
        chk("non_data_flush", int'(flush_req), 0);

        for (int i = 0; i < 9; i++)
            do_txn($sformatf("vec%0d", i), vecs[i].pid, vecs[i].err, vecs[i].occ,
                   vecs[i].active_at, 1'b0);

        // DATA timeout after the OUT token, then a stray DATA0 must be ignored
        send_pkt(4'd1, 1'b0, 7'd0);
        cnt_start = 0; cnt_flush = 0;
        for (int i = 0; i < DATA_TOUT - 1; i++) begin
            step();
            cnt_start += int'(tx_start);
            cnt_flush += int'(flush_req);
        end
        chk("tout_busy_before", int'(resp_busy), 1);
        step();
        chk("tout_busy_after", int'(resp_busy), 0);
        send_pkt(4'd3, 1'b0, 7'd5);
        for (int i = 0; i < 20; i++) begin
            cnt_start += int'(tx_start);
            cnt_flush += int'(flush_req);
            step();
        end
        chk("tout_no_start", cnt_start, 0);
        chk("tout_no_flush", cnt_flush, 0);
        chk("tout_toggle", int'(data_toggle), int'(model_toggle));
        chk("tout_stray_busy", int'(resp_busy), 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] pid;
            pid = ($urandom_range(0, 9) < 7) ? 4'(3 + $urandom_range(0, 1))
                                             : 4'($urandom_range(0, 15));
            if (pid == 4'd1) pid = 4'd2;
            do_txn($sformatf("rnd%0d", i), pid, ($urandom_range(0, 9) == 0),
                   7'($urandom_range(0, 80)),
                   ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 10)) : -1,
                   ($urandom_range(0, 9) < 3));
        end

        // Reset while in TURNAROUND with toggle already advanced to 1
        if (model_toggle) do_txn("pre_rst", 4'd4, 1'b0, 7'd0, -1, 1'b0);
        send_pkt(4'd1, 1'b0, 7'd0);
        step();
        send_pkt(4'd3, 1'b0, 7'd5);
        for (int i = 0; i < 5; i++) step();
        chk("mid_toggle", int'(data_toggle), 1);
        chk("mid_busy", int'(resp_busy), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_tx_packet", int'(tx_packet), 0);
        chk("arst_tx_start", int'(tx_start), 0);
        chk("arst_flush", int'(flush_req), 0);
        chk("arst_toggle", int'(data_toggle), 0);
        chk("arst_busy", int'(resp_busy), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cnt_start = 0; cnt_flush = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt_start += int'(tx_start);
            cnt_flush += int'(flush_req);
        end
        chk("post_rst_no_start", cnt_start, 0);
        chk("post_rst_no_flush", cnt_flush, 0);
        chk("post_rst_busy", int'(resp_busy), 0);
        model_toggle = 1'b0;
        do_txn("post_rst_txn", 4'd3, 1'b0, 7'd1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
